module_mult_ctrl: RTL and testbench

Sequencing controller and iterative datapath for the calculator's multiply path. It captures operand A and then operand B from successive `op_valid` strobes coming from the input-entry logic. It then runs an unsigned shift-add multiplication over WIDTH cycles and presents the product with a valid/ack handshake to the display stage. It replaces the fixed load_a/load_b/load_m pulse sequencer with a handshaked, multi-cycle schedule.

---
 rtl/mult_pkg.sv | 13 +
 rtl/module_shift_add_dp.sv | 67 ++++++
 rtl/module_mult_ctrl.sv | 120 ++++++++++++
 tb/tb_module_mult_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and defaults for the calculator multiply path.
package mult_pkg;

    localparam int MULT_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT_B = 2'd1,
        S_CALC   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/module_shift_add_dp.sv
// Shift-add datapath: operand registers, accumulator, product register and
// the last-iteration flag, all stepped by the sequencer in module_mult_ctrl.
module module_shift_add_dp #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 load_a_en,
    input  logic                 load_b_en,
    input  logic                 step_en,
    input  logic [CW-1:0]        cnt,
    input  logic [WIDTH-1:0]     op_data,
    output logic                 last,
    output logic [2*WIDTH-1:0]   product
);

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_product;

    logic [WIDTH-1:0]   w_b_shift;
    logic               w_b_bit;
    logic [2*WIDTH-1:0] w_a_ext;
    logic [2*WIDTH-1:0] w_addend;
    logic [2*WIDTH-1:0] w_sum;

    // Shift B down rather than index it so the counter width need not match.
    assign w_b_shift = r_b >> cnt;
    assign w_b_bit   = w_b_shift[0];
    assign w_a_ext   = {{WIDTH{1'b0}}, r_a};
    assign w_addend  = w_b_bit ? (w_a_ext << cnt) : '0;
    assign w_sum     = r_acc + w_addend;
    assign last      = (cnt == CW'(WIDTH - 1));
    assign product   = r_product;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_product <= '0;
        end else if (clr) begin
            // Abort drops the operands but keeps the last displayed product.
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
        end else begin
            if (load_a_en) begin
                r_a <= op_data;
            end
            if (load_b_en) begin
                r_b   <= op_data;
                r_acc <= '0;
            end
            if (step_en) begin
                r_acc <= w_sum;
                if (last) begin
                    r_product <= w_sum;
                end
            end
        end
    end

endmodule

// File: rtl/module_mult_ctrl.sv
// Multiply-path sequencer: captures A then B, runs WIDTH shift-add steps,
// then holds the product under a valid/ack handshake.
//
// state    | meaning
// S_IDLE   | waiting for operand A strobe
// S_WAIT_B | A held, waiting for operand B strobe
// S_CALC   | one shift-add step per cycle, WIDTH cycles
// S_DONE   | product valid, waiting for result_ack
module module_mult_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 op_valid,
    input  logic [WIDTH-1:0]     op_data,
    output logic                 load_a,
    output logic                 load_b,
    output logic                 busy,
    output logic                 result_valid,
    input  logic                 result_ack,
    output logic [2*WIDTH-1:0]   product,
    output logic [1:0]           state_o
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_next;
    logic            r_load_a;
    logic            r_load_b;
    logic            w_load_a_en;
    logic            w_load_b_en;
    logic            w_step_en;
    logic            w_last;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_load_a_en  = 1'b0;
        w_load_b_en  = 1'b0;
        w_step_en    = 1'b0;
        if (clr) begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (op_valid) begin
                        w_load_a_en  = 1'b1;
                        w_state_next = S_WAIT_B;
                    end
                end
                S_WAIT_B: begin
                    if (op_valid) begin
                        w_load_b_en  = 1'b1;
                        w_cnt_next   = '0;
                        w_state_next = S_CALC;
                    end
                end
                S_CALC: begin
                    w_step_en  = 1'b1;
                    w_cnt_next = r_cnt + CW'(1);
                    if (w_last) begin
                        w_state_next = S_DONE;
                    end
                end
                S_DONE: begin
                    if (result_ack) begin
                        w_state_next = S_IDLE;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_load_a <= 1'b0;
            r_load_b <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_load_a <= w_load_a_en;
            r_load_b <= w_load_b_en;
        end
    end

    module_shift_add_dp #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_dp (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .load_a_en (w_load_a_en),
        .load_b_en (w_load_b_en),
        .step_en   (w_step_en),
        .cnt       (r_cnt),
        .op_data   (op_data),
        .last      (w_last),
        .product   (product)
    );

    assign load_a       = r_load_a;
    assign load_b       = r_load_b;
    assign busy         = (r_state == S_CALC);
    assign result_valid = (r_state == S_DONE);
    assign state_o      = r_state;

endmodule

// File: tb/tb_module_mult_ctrl.sv
// Directed bench for module_mult_ctrl: expected products are queued when B is
// issued and checked by a monitor whenever result_valid rises.
module tb_module_mult_ctrl;

    localparam int WIDTH = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               clr = 1'b0;
    logic               op_valid = 1'b0;
    logic [WIDTH-1:0]   op_data = '0;
    logic               load_a;
    logic               load_b;
    logic               busy;
    logic               result_valid;
    logic               result_ack = 1'b0;
    logic [2*WIDTH-1:0] product;
    logic [1:0]         state_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [2*WIDTH-1:0] exp_q[$];
    logic rv_prev = 1'b0;

    always #5 clk = ~clk;

    module_mult_ctrl #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .clr          (clr),
        .op_valid     (op_valid),
        .op_data      (op_data),
        .load_a       (load_a),
        .load_b       (load_b),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ack   (result_ack),
        .product      (product),
        .state_o      (state_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pop one expected product on every rising result_valid.
    always @(negedge clk) begin
        if (result_valid && !rv_prev) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL product_unexpected: got %0d with nothing expected", product);
            end else begin
                logic [2*WIDTH-1:0] e;
                e = exp_q.pop_front();
                if (product !== e) begin
                    n_fail++;
                    $display("FAIL product: got %0d expected %0d", product, e);
                end
            end
        end
        rv_prev <= result_valid;
    end

    // All tasks start and end at posedge+1.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_op(input logic [WIDTH-1:0] d);
        op_valid = 1'b1;
        op_data  = d;
        tick();
        op_valid = 1'b0;
    endtask

    // Load A and B, check the load pulses, count busy cycles until DONE.
    task automatic load_and_calc(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input string tag);
        int n_busy;
        int n_edges;
        pulse_op(a);
        check({tag, "_load_a"}, {31'd0, load_a}, 32'd1);
        check({tag, "_state_wait_b"}, {30'd0, state_o}, 32'd1);
        exp_q.push_back(16'(a) * 16'(b));
        pulse_op(b);
        check({tag, "_load_b"}, {31'd0, load_b}, 32'd1);
        n_busy  = 0;
        n_edges = 0;
        while (!result_valid && n_edges < 40) begin
            if (busy) n_busy++;
            tick();
            n_edges++;
        end
        check({tag, "_valid_seen"}, {31'd0, result_valid}, 32'd1);
        check({tag, "_busy_cycles"}, n_busy, WIDTH);
        // Edges counted inclusive of the one that sampled B.
        check({tag, "_latency"}, n_edges + 1, WIDTH + 1);
    endtask

    task automatic ack();
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        check("ack_state_idle", {30'd0, state_o}, 32'd0);
        check("ack_valid_low", {31'd0, result_valid}, 32'd0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_state", {30'd0, state_o}, 32'd0);
        check("rst_product", {16'd0, product}, 32'd0);
        check("rst_outs", {28'd0, load_a, load_b, busy, result_valid}, 32'd0);
        rst = 1'b1;
        tick();

        // 1: 13 * 11
        load_and_calc(8'd13, 8'd11, "t1");
        tick();
        check("t1_product_held", {16'd0, product}, 32'd143);
        ack();

        // 2: full-scale operands
        load_and_calc(8'd255, 8'd255, "t2");
        ack();

        // 3: zero operands still take the full schedule
        load_and_calc(8'd0, 8'd200, "t3a");
        ack();
        load_and_calc(8'd7, 8'd0, "t3b");
        ack();

        // 4: op_valid ignored in CALC and in DONE (with ack)
        pulse_op(8'd20);
        exp_q.push_back(16'd60);
        pulse_op(8'd3);
        tick();
        pulse_op(8'd99);
        check("t4_calc_state", {30'd0, state_o}, 32'd2);
        for (int i = 0; i < 20 && !result_valid; i++) tick();
        check("t4_done", {31'd0, result_valid}, 32'd1);
        op_valid   = 1'b1;
        op_data    = 8'd99;
        result_ack = 1'b1;
        tick();
        op_valid   = 1'b0;
        result_ack = 1'b0;
        check("t4_state_idle", {30'd0, state_o}, 32'd0);
        check("t4_no_load_a", {31'd0, load_a}, 32'd0);
        load_and_calc(8'd9, 8'd9, "t4b");
        ack();

        // 5: clr mid-calculation
        pulse_op(8'd5);
        pulse_op(8'd6);
        tick();
        tick();
        tick();
        check("t5_busy_before_clr", {31'd0, busy}, 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t5_clr_state", {30'd0, state_o}, 32'd0);
        check("t5_clr_busy", {31'd0, busy}, 32'd0);
        check("t5_clr_valid", {31'd0, result_valid}, 32'd0);
        check("t5_product_kept", {16'd0, product}, 32'd81);
        load_and_calc(8'd3, 8'd4, "t5b");
        ack();

        // 6: reset while DONE, then strobes ignored under reset
        load_and_calc(8'd13, 8'd11, "t6");
        rst = 1'b0;
        tick();
        check("t6_rst_state", {30'd0, state_o}, 32'd0);
        check("t6_rst_product", {16'd0, product}, 32'd0);
        check("t6_rst_outs", {28'd0, load_a, load_b, busy, result_valid}, 32'd0);
        pulse_op(8'd50);
        pulse_op(8'd60);
        check("t6_rst_hold_state", {30'd0, state_o}, 32'd0);
        check("t6_rst_hold_load", {31'd0, load_a}, 32'd0);
        rst = 1'b1;
        tick();
        load_and_calc(8'd2, 8'd3, "t6b");
        ack();

        tick();
        tick();
        check("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
